// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/mem/writeback and drives the datapath.
// Optional JAL support is enabled by defining MC_CTRL_JAL_EN; without it opcode 000011 traps.
module multicycle_control_fsm #(
   parameter int NB_ALUOP    = 3,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                i_rst,
   input  logic [5:0]          i_opcode,
   input  logic                i_zero,
   input  logic                i_mem_ready,
   output logic                o_pc_write,
   output logic [1:0]          o_pc_src,
   output logic                o_ir_write,
   output logic                o_iord,
   output logic                o_mem_read,
   output logic                o_mem_write,
   output logic                o_reg_write,
   output logic [1:0]          o_reg_dst,
   output logic [1:0]          o_mem2reg,
   output logic                o_alu_src_a,
   output logic [1:0]          o_alu_src_b,
   output logic                o_ext_zero,
   output logic [NB_ALUOP-1:0] o_alu_op,
   output logic [3:0]          o_state,
   output logic                o_error
);

   typedef enum logic [3:0] {
      S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3,
      S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_EXEC_R = 4'd6, S_R_WB = 4'd7,
      S_BRANCH = 4'd8, S_JUMP = 4'd9, S_EXEC_I = 4'd10, S_I_WB = 4'd11,
      S_TRAP = 4'd12, S_JAL = 4'd13
   } state_t;

   typedef struct packed {
      logic                pc_write;
      logic [1:0]          pc_src;
      logic                ir_write;
      logic                iord;
      logic                mem_read;
      logic                mem_write;
      logic                reg_write;
      logic [1:0]          reg_dst;
      logic [1:0]          mem2reg;
      logic                alu_src_a;
      logic [1:0]          alu_src_b;
      logic                ext_zero;
      logic [NB_ALUOP-1:0] alu_op;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                          OP_JAL = 6'b000011, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010,
                          OP_ANDI = 6'b001100, OP_ORI = 6'b001101;

   localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] LIM = CW'(MEM_TIMEOUT - 1);

   state_t        state, nxt;
   ctrl_t         outs, ctrl;
   logic [5:0]    opc_q, op_next;
   logic [CW-1:0] cnt;
   logic          wait_st;

   // Moore part of the control word; registered so it is valid from the first cycle of a state.
   function automatic ctrl_t moore(input state_t s, input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:     begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
         S_DECODE:    c.alu_src_b = 2'b11;
         S_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         S_MEM_READ:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
         S_MEM_WB:    begin c.reg_write = 1'b1; c.mem2reg = 2'b01; end
         S_MEM_WRITE: begin c.mem_write = 1'b1; c.iord = 1'b1; end
         S_EXEC_R:    begin c.alu_src_a = 1'b1; c.alu_op = NB_ALUOP'(3'd2); end
         S_R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 2'b01; end
         S_BRANCH:    begin c.alu_src_a = 1'b1; c.alu_op = NB_ALUOP'(3'd1); c.pc_src = 2'b01; end
         S_JUMP:      begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
         S_EXEC_I: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            case (op)
               OP_SLTI: c.alu_op = NB_ALUOP'(3'd5);
               OP_ANDI: begin c.alu_op = NB_ALUOP'(3'd3); c.ext_zero = 1'b1; end
               OP_ORI:  begin c.alu_op = NB_ALUOP'(3'd4); c.ext_zero = 1'b1; end
               default: c.alu_op = NB_ALUOP'(3'd0);
            endcase
         end
         S_I_WB:      c.reg_write = 1'b1;
         S_JAL: begin
            c.pc_write  = 1'b1; c.pc_src  = 2'b10; c.reg_write = 1'b1;
            c.reg_dst   = 2'b10; c.mem2reg = 2'b10;
         end
         default:     c = '0;
      endcase
      return c;
   endfunction

   assign wait_st = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
   assign op_next = (state == S_DECODE) ? i_opcode : opc_q;

   always_comb begin
      nxt = state;
      case (state)
         S_FETCH:     if (i_mem_ready) nxt = S_DECODE;
         S_DECODE: begin
            case (i_opcode)
               OP_RTYPE:                          nxt = S_EXEC_R;
               OP_LW, OP_SW:                      nxt = S_MEM_ADDR;
               OP_BEQ, OP_BNE:                    nxt = S_BRANCH;
               OP_J:                              nxt = S_JUMP;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: nxt = S_EXEC_I;
`ifdef MC_CTRL_JAL_EN
               OP_JAL:                            nxt = S_JAL;
`else
               OP_JAL:                            nxt = S_TRAP;
`endif
               default:                           nxt = S_TRAP;
            endcase
         end
         S_MEM_ADDR:  nxt = (opc_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  if (i_mem_ready) nxt = S_MEM_WB;
         S_MEM_WRITE: if (i_mem_ready) nxt = S_FETCH;
         S_EXEC_R:    nxt = S_R_WB;
         S_EXEC_I:    nxt = S_I_WB;
         S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL: nxt = S_FETCH;
         S_TRAP:      nxt = S_TRAP;
         default:     nxt = S_TRAP;
      endcase
      // A ready arriving on the limit cycle still advances normally.
      if (wait_st && !i_mem_ready && cnt == LIM) nxt = S_TRAP;
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state   <= S_FETCH;
         cnt     <= '0;
         o_error <= 1'b0;
         opc_q   <= '0;
         outs    <= moore(S_FETCH, 6'b0);
      end else begin
         state   <= nxt;
         cnt     <= (wait_st && !i_mem_ready && nxt == state) ? cnt + CW'(1) : '0;
         o_error <= o_error | (nxt == S_TRAP);
         if (state == S_DECODE) opc_q <= i_opcode;
         outs    <= moore(nxt, op_next);
      end
   end

   // Handshake-dependent terms are combinational so the datapath acts in the completing cycle.
   always_comb begin
      ctrl = outs;
      if (state == S_FETCH && i_mem_ready) begin
         ctrl.pc_write = 1'b1;
         ctrl.ir_write = 1'b1;
      end
      if (state == S_BRANCH) ctrl.pc_write = (opc_q == OP_BEQ) ? i_zero : !i_zero;
      if (i_rst) ctrl = '0;
   end

   assign o_pc_write  = ctrl.pc_write;
   assign o_pc_src    = ctrl.pc_src;
   assign o_ir_write  = ctrl.ir_write;
   assign o_iord      = ctrl.iord;
   assign o_mem_read  = ctrl.mem_read;
   assign o_mem_write = ctrl.mem_write;
   assign o_reg_write = ctrl.reg_write;
   assign o_reg_dst   = ctrl.reg_dst;
   assign o_mem2reg   = ctrl.mem2reg;
   assign o_alu_src_a = ctrl.alu_src_a;
   assign o_alu_src_b = ctrl.alu_src_b;
   assign o_ext_zero  = ctrl.ext_zero;
   assign o_alu_op    = ctrl.alu_op;
   assign o_state     = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: instruction-level model of state sequences and
// control words, per-cycle compare process, plus literal expectations for key cycles.
module tb_multicycle_control_fsm;
   localparam int TMO = 4;

   logic       clk = 1'b0;
   logic       i_rst = 1'b1, i_zero = 1'b0, i_mem_ready = 1'b0;
   logic [5:0] i_opcode = 6'b0;
   logic       o_pc_write, o_ir_write, o_iord, o_mem_read, o_mem_write, o_reg_write;
   logic       o_alu_src_a, o_ext_zero, o_error;
   logic [1:0] o_pc_src, o_reg_dst, o_mem2reg, o_alu_src_b;
   logic [2:0] o_alu_op;
   logic [3:0] o_state;

   multicycle_control_fsm #(.NB_ALUOP(3), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_zero(i_zero), .i_mem_ready(i_mem_ready),
      .o_pc_write(o_pc_write), .o_pc_src(o_pc_src), .o_ir_write(o_ir_write), .o_iord(o_iord),
      .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_reg_write(o_reg_write),
      .o_reg_dst(o_reg_dst), .o_mem2reg(o_mem2reg), .o_alu_src_a(o_alu_src_a),
      .o_alu_src_b(o_alu_src_b), .o_ext_zero(o_ext_zero), .o_alu_op(o_alu_op),
      .o_state(o_state), .o_error(o_error));

   always #5 clk = ~clk;

   int          checks = 0, errors = 0;
   bit          e_on = 0, e_full = 0, e_err = 0, m_err = 0, rec = 0;
   logic [3:0]  e_state = '0;
   logic [18:0] e_word = '0, act;
   logic [3:0]  sh[$];
   logic [18:0] wh[$];

   // Control word the spec requires for phase ph of instruction op.
   function automatic logic [18:0] ctl(input int ph, input logic [5:0] op, input logic rdy, input logic z);
      logic pw, irw, io, mr, mw, rw, sa, ez;
      logic [1:0] ps, rd, m2r, sb;
      logic [2:0] ao;
      {pw, irw, io, mr, mw, rw, sa, ez} = '0;
      {ps, rd, m2r, sb} = '0;
      ao = '0;
      case (ph)
         0:  begin mr = 1; sb = 2'd1; pw = rdy; irw = rdy; end
         1:  sb = 2'd3;
         2:  begin sa = 1; sb = 2'd2; end
         3:  begin mr = 1; io = 1; end
         4:  begin rw = 1; m2r = 2'd1; end
         5:  begin mw = 1; io = 1; end
         6:  begin sa = 1; ao = 3'd2; end
         7:  begin rw = 1; rd = 2'd1; end
         8:  begin sa = 1; ao = 3'd1; ps = 2'd1; pw = (op == 6'b000100) ? z : !z; end
         9:  begin pw = 1; ps = 2'd2; end
         10: begin
            sa = 1; sb = 2'd2;
            ao = (op == 6'b001010) ? 3'd5 : (op == 6'b001100) ? 3'd3 : (op == 6'b001101) ? 3'd4 : 3'd0;
            ez = (op == 6'b001100) || (op == 6'b001101);
         end
         11: rw = 1;
         13: begin pw = 1; ps = 2'd2; rw = 1; rd = 2'd2; m2r = 2'd2; end
         default: ;
      endcase
      return {pw, ps, irw, io, mr, mw, rw, rd, m2r, sa, sb, ez, ao};
   endfunction

   always @(negedge clk) begin
      if (e_on) begin
         act = {o_pc_write, o_pc_src, o_ir_write, o_iord, o_mem_read, o_mem_write, o_reg_write,
                o_reg_dst, o_mem2reg, o_alu_src_a, o_alu_src_b, o_ext_zero, o_alu_op};
         checks++;
         if (act !== e_word || (e_full && (o_state !== e_state || o_error !== e_err))) begin
            errors++;
            $display("FAIL cycle t=%0t state %0d want %0d word %b want %b error %b want %b",
                     $time, o_state, e_state, act, e_word, o_error, e_err);
         end
         if (rec) begin sh.push_back(o_state); wh.push_back(act); end
      end
   end

   task automatic lit(input string name, input logic [31:0] a, input logic [31:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, a, x);
      end
   endtask

   task automatic cyc(input logic rst, input logic [5:0] dop, input logic [5:0] mop,
                      input logic rdy, input logic z, input int st);
      i_rst = rst; i_opcode = dop; i_mem_ready = rdy; i_zero = z;
      e_full = !rst; e_state = st[3:0]; e_err = m_err;
      e_word = rst ? 19'b0 : ctl(st, mop, rdy, z);
      e_on = 1;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      cyc(1'b1, 6'h2a, 6'h2a, 1'b1, 1'b1, 0);
      m_err = 0;
   endtask

   task automatic trap_hold(input int n);
      m_err = 1;
      for (int i = 0; i < n; i++) cyc(1'b0, 6'h00, 6'h00, i[0], 1'b0, 12);
   endtask

   // n cycles without ready, then a completing cycle unless the limit is reached first.
   task automatic wait_phase(input int ph, input logic [5:0] dop, input logic [5:0] mop,
                             input int n, output bit tr);
      int k;
      k = (n < TMO) ? n : TMO;
      for (int i = 0; i < k; i++) cyc(1'b0, dop, mop, 1'b0, 1'b0, ph);
      tr = (n >= TMO);
      if (!tr) cyc(1'b0, dop, mop, 1'b1, 1'b0, ph);
   endtask

   task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
      int seq[$];
      bit tr;
      logic [5:0] junk;
      junk = op ^ 6'h3f;
      wait_phase(0, op, op, fw, tr);
      if (tr) begin trap_hold(2); return; end
      cyc(1'b0, op, op, 1'b0, z, 1);
      case (op)
         6'b000000: seq = '{6, 7};
         6'b100011: seq = '{2, 3, 4};
         6'b101011: seq = '{2, 5};
         6'b000100, 6'b000101: seq = '{8};
         6'b000010: seq = '{9};
         6'b001000, 6'b001010, 6'b001100, 6'b001101: seq = '{10, 11};
`ifdef MC_CTRL_JAL_EN
         6'b000011: seq = '{13};
`endif
         default: seq = '{12};
      endcase
      foreach (seq[i]) begin
         if (seq[i] == 3 || seq[i] == 5) begin
            wait_phase(seq[i], junk, op, mw, tr);
            if (tr) begin trap_hold(2); return; end
         end else if (seq[i] == 12) begin
            trap_hold(2);
            return;
         end else begin
            cyc(1'b0, junk, op, 1'b0, z, seq[i]);
         end
      end
   endtask

   initial begin
      logic [3:0] t1 [7];
      t1 = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      do_reset();
      do_reset();
      lit("reset_state", {28'b0, o_state}, 32'd0);
      lit("reset_error", {31'b0, o_error}, 32'd0);

      // LW with FETCH ready on 3rd cycle, MEM_READ ready immediately
      sh.delete(); wh.delete(); rec = 1;
      run_instr(6'b100011, 1'b0, 2, 0);
      rec = 0;
      lit("lw_len", sh.size(), 32'd7);
      for (int i = 0; i < 7; i++) if (i < sh.size()) lit("lw_seq", {28'b0, sh[i]}, {28'b0, t1[i]});
      if (wh.size() == 7) lit("lw_wb_word", {13'b0, wh[6]}, {13'b0, 19'b0_00_0_0_0_0_1_00_01_0_00_0_000});
      lit("lw_back_fetch", {28'b0, o_state}, 32'd0);

      // branches, both polarities of zero
      sh.delete(); wh.delete(); rec = 1;
      run_instr(6'b000100, 1'b1, 0, 0);
      rec = 0;
      if (wh.size() == 3) lit("beq_taken_word", {13'b0, wh[2]}, {13'b0, 19'b1_01_0_0_0_0_0_00_00_1_00_0_001});
      run_instr(6'b000100, 1'b0, 0, 0);
      run_instr(6'b000101, 1'b1, 0, 0);
      run_instr(6'b000101, 1'b0, 1, 0);

      // I-type, R-type, jump, stores
      sh.delete(); wh.delete(); rec = 1;
      run_instr(6'b001101, 1'b0, 0, 0);
      rec = 0;
      if (wh.size() == 4) lit("ori_exec_word", {13'b0, wh[2]}, {13'b0, 19'b0_00_0_0_0_0_0_00_00_1_10_1_100});
      run_instr(6'b001000, 1'b0, 0, 0);
      run_instr(6'b001010, 1'b0, 0, 0);
      run_instr(6'b001100, 1'b1, 0, 0);
      run_instr(6'b000000, 1'b0, 0, 0);
      run_instr(6'b000010, 1'b0, 0, 0);
      run_instr(6'b101011, 1'b0, 0, 2);
      run_instr(6'b100011, 1'b0, 3, 3);

      // FETCH timeout, then MEM_READ timeout
      run_instr(6'b000000, 1'b0, 4, 0);
      lit("tmo_state", {28'b0, o_state}, 32'd12);
      lit("tmo_error", {31'b0, o_error}, 32'd1);
      do_reset();
      run_instr(6'b100011, 1'b0, 0, 5);
      do_reset();

      // illegal opcode traps and sticks until reset
      run_instr(6'b111111, 1'b0, 0, 0);
      trap_hold(20);
      do_reset();
      lit("trap_cleared", {31'b0, o_error}, 32'd0);
      run_instr(6'b000000, 1'b0, 0, 0);

      // reset in the middle of MEM_WRITE
      cyc(1'b0, 6'b101011, 6'b101011, 1'b1, 1'b0, 0);
      cyc(1'b0, 6'b101011, 6'b101011, 1'b0, 1'b0, 1);
      cyc(1'b0, 6'b101011, 6'b101011, 1'b0, 1'b0, 2);
      cyc(1'b0, 6'b101011, 6'b101011, 1'b0, 1'b0, 5);
      do_reset();
      lit("mid_reset_state", {28'b0, o_state}, 32'd0);
      run_instr(6'b000011, 1'b0, 0, 0);
      do_reset();
      run_instr(6'b000010, 1'b0, 0, 0);

      e_on = 0;
      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
